// File: rtl/adder_pipe.sv
// adder_pipe: pipelined, carry-chunked add/subtract unit behind valid/ready.
// Each stage resolves one CHUNK-bit slice of the result and passes its carry
// to the next stage through a register, so a WIDTH-bit operation takes
// STAGES = WIDTH/CHUNK cycles. Back-pressure propagates combinationally from
// out_ready through the stage chain to in_ready.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int RES_W  = WIDTH + 2;

    // Resolves chunk k of x+y+c and merges it into the partial result s.
    // Returns {overflow, carry_out, merged_result}. The overflow bit is only
    // meaningful for the top chunk: carry into its MSB is recovered as
    // x^y^sum at that bit position, then XORed with the carry out.
    function automatic logic [RES_W-1:0] step_chunk(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] s,
        input logic             c,
        input int               k
    );
        logic [CHUNK-1:0] xc;
        logic [CHUNK-1:0] yc;
        logic [CHUNK:0]   r;
        logic [WIDTH-1:0] ns;
        logic             cmsb;
        xc   = x[k*CHUNK +: CHUNK];
        yc   = y[k*CHUNK +: CHUNK];
        r    = {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, c};
        ns   = s;
        ns[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
        cmsb = xc[CHUNK-1] ^ yc[CHUNK-1] ^ r[CHUNK-1];
        return {r[CHUNK] ^ cmsb, r[CHUNK], ns};
    endfunction

    // Stage registers. Index k holds the state after chunk k is resolved;
    // the last stage lives in the output ports sum/cout/ovf instead.
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] en;
    logic [WIDTH-1:0]  a_p [STAGES];
    logic [WIDTH-1:0]  b_p [STAGES];
    logic [WIDTH-1:0]  s_p [STAGES];
    logic              c_p [STAGES];
    logic [RES_W-1:0]  nx  [STAGES];
    logic [WIDTH-1:0]  b_in;
    logic              last_src_vld;

    // Subtraction is a + ~b + 1, so B is inverted once on entry and the
    // forced carry-in supplies the +1.
    assign b_in = sub ? ~b : b;

    generate
        if (STAGES == 1) begin : g_single
            assign last_src_vld = in_valid;
        end else begin : g_multi
            assign last_src_vld = vld_p[STAGES-2];
        end
    endgenerate

    assign out_valid = vld_p[STAGES-1];
    assign in_ready  = en[0];

    // Load enables: a stage may load when it is empty or its contents move on.
    always_comb begin
        logic go;
        en = '0;
        go = !vld_p[STAGES-1] || out_ready;
        en[STAGES-1] = go;
        for (int k = STAGES - 2; k >= 0; k--) begin
            go    = !vld_p[k] || go;
            en[k] = go;
        end
    end

    // Next-state value of every stage, computed from its predecessor.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx[k] = '0;
        end
        nx[0] = step_chunk(a, b_in, {WIDTH{1'b0}}, sub | cin, 0);
        for (int k = 1; k < STAGES; k++) begin
            nx[k] = step_chunk(a_p[k-1], b_p[k-1], s_p[k-1], c_p[k-1], k);
        end
    end

    // Stage valid bits: cleared by reset, shifted forward under the enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            if (en[0]) begin
                vld_p[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (en[k]) begin
                    vld_p[k] <= vld_p[k-1];
                end
            end
        end
    end

    // Intermediate stage data: loaded only when a valid operation moves in.
    always_ff @(posedge clk) begin
        // p0: capture operands and resolve chunk 0
        if (en[0] && in_valid) begin
            a_p[0] <= a;
            b_p[0] <= b_in;
            s_p[0] <= nx[0][WIDTH-1:0];
            c_p[0] <= nx[0][WIDTH];
        end
        // pk: resolve chunk k from the stored operands and carry
        for (int k = 1; k < STAGES - 1; k++) begin
            if (en[k] && vld_p[k-1]) begin
                a_p[k] <= a_p[k-1];
                b_p[k] <= b_p[k-1];
                s_p[k] <= nx[k][WIDTH-1:0];
                c_p[k] <= nx[k][WIDTH];
            end
        end
    end

    // Final stage registers the visible result; cleared on reset and held
    // stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (en[STAGES-1] && last_src_vld) begin
            sum  <= nx[STAGES-1][WIDTH-1:0];
            cout <= nx[STAGES-1][WIDTH];
            ovf  <= nx[STAGES-1][WIDTH+1];
        end
    end

endmodule
